// File: rtl/hamming_encode_serializer_pkg.sv
// Shared definitions for the Hamming(15,11) serial transmit path.
//   - FSM state encoding for the serializer
//   - FRAME_LEN (15, or 16 when HAM_OVERALL_PARITY_EN is defined)
//   - data-bit to codeword-position map
//   - ham_encode(): 11-bit data -> 15-bit codeword, also used by the decoder's syndrome logic
// Codeword bit index i holds codeword position i+1.
package hamming_encode_serializer_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  localparam int DATA_LEN = 11;
  localparam int CW_LEN   = 15;

`ifdef HAM_OVERALL_PARITY_EN
  localparam int FRAME_LEN = 16;
`else
  localparam int FRAME_LEN = 15;
`endif

  // Codeword position (1-based) of d[0] .. d[10].
  localparam logic [3:0] DATA_POS [DATA_LEN] = '{
    4'd3, 4'd5, 4'd6, 4'd7, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15
  };

  function automatic logic [CW_LEN-1:0] ham_encode(input logic [DATA_LEN-1:0] d);
    logic [CW_LEN-1:0] cw;
    logic              par;
    cw = '0;
    for (int i = 0; i < DATA_LEN; i++) begin
      cw[DATA_POS[i] - 4'd1] = d[i];
    end
    // Parity positions are still zero here, and position 2^j never has bit k set
    // for j != k, so each parity sees only data positions.
    for (int k = 0; k < 4; k++) begin
      par = 1'b0;
      for (int pos = 1; pos <= CW_LEN; pos++) begin
        if (pos[k]) par ^= cw[pos-1];
      end
      cw[(1 << k) - 1] = par;
    end
    return cw;
  endfunction

endpackage

// File: rtl/hamming_15_11_enc.sv
// Pure combinational Hamming(15,11) encoder.
// Ports:
//   data     in  11  data word, d[0] is the first data position
//   codeword out 15  bit i = codeword position i+1
module hamming_15_11_enc
  import hamming_encode_serializer_pkg::*;
(
  input  logic [DATA_LEN-1:0] data,
  output logic [CW_LEN-1:0]   codeword
);

  assign codeword = ham_encode(data);

endmodule

// File: rtl/hamming_encode_serializer.sv
// Hamming(15,11) encoder + serializer. Accepts an 11-bit word on a valid/ready
// handshake, encodes it, and shifts the frame out one bit per DEVICE_EN cycle with
// frame start/end markers. Back-to-back frames run with no gap when DATA_VALID is
// held high.
// Build option: define HAM_OVERALL_PARITY_EN to append position 16 (overall even
// parity of positions 1..15, SECDED); FRAME_LEN becomes 16.
// Parameters:
//   MSB_FIRST  0: position 1 sent first; 1: highest position sent first
//   IDLE_LVL   SER_OUT level while no frame is active
// Ports:
//   CLK          in   clock, posedge
//   REST         in   synchronous active-low reset
//   DEVICE_EN    in   bit-rate enable
//   DATA_IN      in   11-bit data word
//   DATA_VALID   in   DATA_IN valid
//   DATA_READY   out  word can be accepted this cycle
//   SER_OUT      out  serial bit
//   SER_VALID    out  SER_OUT carries a frame bit
//   FRAME_START  out  first bit of frame
//   FRAME_END    out  last bit of frame
//   BUSY         out  frame in progress
//
// state  | meaning
// IDLE   | no frame, ready for a word
// SHIFT  | frame bits being sent, count = index of bit on SER_OUT
module hamming_encode_serializer
  import hamming_encode_serializer_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b0,
  parameter bit IDLE_LVL  = 1'b0
) (
  input  logic                CLK,
  input  logic                REST,
  input  logic                DEVICE_EN,
  input  logic [DATA_LEN-1:0] DATA_IN,
  input  logic                DATA_VALID,
  output logic                DATA_READY,
  output logic                SER_OUT,
  output logic                SER_VALID,
  output logic                FRAME_START,
  output logic                FRAME_END,
  output logic                BUSY
);

  localparam logic [3:0] LAST_CNT = 4'(FRAME_LEN - 1);

  state_t               state;
  logic [3:0]           count;
  logic [FRAME_LEN-1:0] shreg;
  logic [FRAME_LEN-1:0] shreg_next;
  logic [FRAME_LEN-1:0] frame;
  logic [CW_LEN-1:0]    codeword;
  logic                 last_bit;
  logic                 accept;

  hamming_15_11_enc u_enc (
    .data     (DATA_IN),
    .codeword (codeword)
  );

`ifdef HAM_OVERALL_PARITY_EN
  assign frame = {^codeword, codeword};
`else
  assign frame = codeword;
`endif

  // The head of the register is always the bit on the wire, so the shift
  // direction follows MSB_FIRST.
  always_comb begin
    shreg_next = shreg;
    if (MSB_FIRST) shreg_next = {shreg[FRAME_LEN-2:0], 1'b0};
    else           shreg_next = {1'b0, shreg[FRAME_LEN-1:1]};
  end

  assign last_bit   = (state == ST_SHIFT) && (count == LAST_CNT);
  assign DATA_READY = (state == ST_IDLE) || (last_bit && DEVICE_EN);
  assign accept     = DATA_READY && DATA_VALID;

  assign SER_OUT = (state == ST_SHIFT)
                   ? (MSB_FIRST ? shreg[FRAME_LEN-1] : shreg[0])
                   : IDLE_LVL;

  always_ff @(posedge CLK) begin
    if (!REST) begin
      state       <= ST_IDLE;
      count       <= 4'd0;
      shreg       <= '0;
      SER_VALID   <= 1'b0;
      FRAME_START <= 1'b0;
      FRAME_END   <= 1'b0;
      BUSY        <= 1'b0;
    end else if (accept) begin
      // Covers both the IDLE handshake and the gapless reload on the last bit.
      state       <= ST_SHIFT;
      count       <= 4'd0;
      shreg       <= frame;
      SER_VALID   <= 1'b1;
      FRAME_START <= 1'b1;
      FRAME_END   <= 1'b0;
      BUSY        <= 1'b1;
    end else if (state == ST_SHIFT && DEVICE_EN) begin
      if (last_bit) begin
        state       <= ST_IDLE;
        count       <= 4'd0;
        shreg       <= '0;
        SER_VALID   <= 1'b0;
        FRAME_START <= 1'b0;
        FRAME_END   <= 1'b0;
        BUSY        <= 1'b0;
      end else begin
        count       <= count + 4'd1;
        shreg       <= shreg_next;
        FRAME_START <= 1'b0;
        FRAME_END   <= ((count + 4'd1) == LAST_CNT);
      end
    end
  end

endmodule

// File: tb/tb_hamming_encode_serializer.sv
module tb_hamming_encode_serializer;

`ifdef HAM_OVERALL_PARITY_EN
  localparam int FL = 16;
  localparam logic [15:0] F000 = 16'h0000;
  localparam logic [15:0] F7FF = 16'hFFFF;
  localparam logic [15:0] F001 = 16'h8007;
  localparam logic [15:0] F400 = 16'hC08B;
`else
  localparam int FL = 15;
  localparam logic [15:0] F000 = 16'h0000;
  localparam logic [15:0] F7FF = 16'h7FFF;
  localparam logic [15:0] F001 = 16'h0007;
  localparam logic [15:0] F400 = 16'h408B;
`endif

  logic        clk = 1'b0;
  logic        rest;
  logic        device_en;
  logic [10:0] data_in;
  logic        data_valid;
  logic        data_ready, ser_out, ser_valid, frame_start, frame_end, busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hamming_encode_serializer #(.MSB_FIRST(1'b0), .IDLE_LVL(1'b0)) dut (
    .CLK         (clk),
    .REST        (rest),
    .DEVICE_EN   (device_en),
    .DATA_IN     (data_in),
    .DATA_VALID  (data_valid),
    .DATA_READY  (data_ready),
    .SER_OUT     (ser_out),
    .SER_VALID   (ser_valid),
    .FRAME_START (frame_start),
    .FRAME_END   (frame_end),
    .BUSY        (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rest = 1'b0; device_en = 1'b1; data_valid = 1'b0; data_in = 11'h000;
    repeat (3) tick();
    n_checks++;
    if (ser_out !== 1'b0) begin n_fail++; $display("FAIL reset_ser_out got %b want 0", ser_out); end
    n_checks++;
    if (data_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", data_ready); end
    n_checks++;
    if ({ser_valid, frame_start, frame_end, busy} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_flags got %b want 0000", {ser_valid, frame_start, frame_end, busy});
    end
    rest = 1'b1;
    tick();
    n_checks++;
    if ({busy, data_ready, ser_out} !== 3'b010) begin
      n_fail++; $display("FAIL reset_release got %b want 010", {busy, data_ready, ser_out});
    end
  endtask

  task automatic test_encode();
    logic [10:0] words [3];
    logic [15:0] exps  [3];
    logic [15:0] got;
    words = '{11'h000, 11'h7FF, 11'h001};
    exps  = '{F000, F7FF, F001};
    device_en = 1'b1;
    for (int w = 0; w < 3; w++) begin
      n_checks++;
      if (data_ready !== 1'b1) begin n_fail++; $display("FAIL encode_ready w%0d got %b want 1", w, data_ready); end
      data_in = words[w]; data_valid = 1'b1;
      tick();
      data_valid = 1'b0;
      got = '0;
      for (int i = 0; i < FL; i++) begin
        n_checks++;
        if (ser_valid !== 1'b1 || busy !== 1'b1 || frame_start !== 1'(i == 0) || frame_end !== 1'(i == FL-1)) begin
          n_fail++;
          $display("FAIL encode_marks w%0d bit%0d got v%b b%b s%b e%b want v1 b1 s%b e%b",
                   w, i, ser_valid, busy, frame_start, frame_end, i == 0, i == FL-1);
        end
        got[i] = ser_out;
        tick();
      end
      n_checks++;
      if (got !== exps[w]) begin n_fail++; $display("FAIL encode_word w%0d got %h want %h", w, got, exps[w]); end
      n_checks++;
      if ({busy, ser_valid, ser_out, data_ready} !== 4'b0001) begin
        n_fail++; $display("FAIL encode_idle w%0d got %b want 0001", w, {busy, ser_valid, ser_out, data_ready});
      end
    end
  endtask

  task automatic test_enable_stall();
    logic [15:0] exp;
    int          bidx;
    logic        en;
    exp = F001;
    device_en = 1'b1;
    data_in = 11'h001; data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    bidx = 0;
    // Drops at cycle 4 (mid-frame) and cycle FL (on the last bit).
    for (int c = 0; c < FL + 2; c++) begin
      en = !(c == 4 || c == FL);
      device_en = en;
      #1;
      n_checks++;
      if (ser_out !== exp[bidx] || frame_end !== 1'(bidx == FL-1) || busy !== 1'b1 ||
          data_ready !== 1'(bidx == FL-1 && en)) begin
        n_fail++;
        $display("FAIL stall_cycle c%0d got o%b e%b b%b r%b want o%b e%b b1 r%b",
                 c, ser_out, frame_end, busy, data_ready, exp[bidx], bidx == FL-1, bidx == FL-1 && en);
      end
      tick();
      if (en) bidx++;
    end
    device_en = 1'b1;
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL stall_length busy got %b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    logic [10:0] words [3];
    logic [15:0] exps  [3];
    logic [15:0] exp;
    words = '{11'h7FF, 11'h001, 11'h400};
    exps  = '{F7FF, F001, F400};
    device_en = 1'b1;
    data_in = words[0]; data_valid = 1'b1;
    tick();
    for (int f = 0; f < 3; f++) begin
      exp = exps[f];
      for (int i = 0; i < FL; i++) begin
        n_checks++;
        if (ser_out !== exp[i] || ser_valid !== 1'b1 || frame_start !== 1'(i == 0) ||
            data_ready !== 1'(i == FL-1)) begin
          n_fail++;
          $display("FAIL b2b f%0d bit%0d got o%b v%b s%b r%b want o%b v1 s%b r%b",
                   f, i, ser_out, ser_valid, frame_start, data_ready, exp[i], i == 0, i == FL-1);
        end
        if (i == 0) data_in = (f < 2) ? words[f+1] : 11'h555;
        if (f == 2 && i == FL-1) data_valid = 1'b0;
        tick();
      end
    end
    n_checks++;
    if ({busy, ser_valid, data_ready} !== 3'b001) begin
      n_fail++; $display("FAIL b2b_end got %b want 001", {busy, ser_valid, data_ready});
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [15:0] got;
    device_en = 1'b1;
    data_in = 11'h7FF; data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    repeat (6) tick();
    n_checks++;
    if ({busy, ser_out} !== 2'b11) begin n_fail++; $display("FAIL rst_mid_pre got %b want 11", {busy, ser_out}); end
    rest = 1'b0;
    tick();
    n_checks++;
    if ({busy, ser_valid, ser_out, data_ready, frame_start, frame_end} !== 6'b000100) begin
      n_fail++;
      $display("FAIL rst_mid_state got %b want 000100", {busy, ser_valid, ser_out, data_ready, frame_start, frame_end});
    end
    rest = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      n_checks++;
      if ({busy, ser_valid, ser_out} !== 3'b000) begin
        n_fail++; $display("FAIL rst_mid_residual c%0d got %b want 000", c, {busy, ser_valid, ser_out});
      end
    end
    data_in = 11'h001; data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    got = '0;
    for (int i = 0; i < FL; i++) begin
      got[i] = ser_out;
      tick();
    end
    n_checks++;
    if (got !== F001) begin n_fail++; $display("FAIL rst_mid_recover got %h want %h", got, F001); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_encode();
    test_enable_stall();
    test_back_to_back();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
